// File: rtl/axi_stream_merge3.sv
// axi_stream_merge3: three-input AXI-Stream merger with one small FIFO per
// input, a round-robin arbiter, and a registered, tagged output stage.
// Each output beat is {port_id[1:0], payload}.
//
// Handshake semantics: on every port, a beat transfers on a rising clk edge
// where tvalid && tready are both high. A source holds tvalid/tdata stable
// until the transfer happens. sN_tready depends only on registered FIFO
// occupancy. m_tvalid/m_tdata are registers and do not change while they are
// stalled by m_tready low.
module axi_stream_merge3 #(
    parameter int DATA_W     = 22,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s0_tvalid,
    input  logic [DATA_W-1:0]             s0_tdata,
    output logic                          s0_tready,
    input  logic                          s1_tvalid,
    input  logic [DATA_W-1:0]             s1_tdata,
    output logic                          s1_tready,
    input  logic                          s2_tvalid,
    input  logic [DATA_W-1:0]             s2_tdata,
    output logic                          s2_tready,
    output logic                          m_tvalid,
    output logic [DATA_W+1:0]             m_tdata,
    input  logic                          m_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fill0,
    output logic [$clog2(FIFO_DEPTH):0]   fill1,
    output logic [$clog2(FIFO_DEPTH):0]   fill2
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    // Per-port views of the inputs so the FIFO logic can be written once.
    logic [2:0]        in_valid;
    logic [DATA_W-1:0] in_data [3];

    // FIFO storage and bookkeeping. Pointers wrap naturally because the
    // depth is a power of two.
    logic [DATA_W-1:0] mem [3][FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr [3];
    logic [PW-1:0]     rd_ptr [3];
    logic [CW-1:0]     fill [3];

    logic [2:0] not_full;
    logic [2:0] not_empty;
    logic [2:0] push;
    logic [2:0] pop;

    // Arbiter state and decisions.
    logic [1:0]        last_grant;
    logic [1:0]        grant_port;
    logic              grant_valid;
    logic              out_free;
    logic [DATA_W-1:0] head_data;

    assign in_valid   = {s2_tvalid, s1_tvalid, s0_tvalid};
    assign in_data[0] = s0_tdata;
    assign in_data[1] = s1_tdata;
    assign in_data[2] = s2_tdata;

    assign s0_tready = not_full[0];
    assign s1_tready = not_full[1];
    assign s2_tready = not_full[2];
    assign fill0     = fill[0];
    assign fill1     = fill[1];
    assign fill2     = fill[2];

    // FIFO status from registered occupancy; a full FIFO refuses writes
    // even if it is popped in the same cycle.
    always_comb begin
        not_full  = '0;
        not_empty = '0;
        push      = '0;
        for (int i = 0; i < 3; i++) begin
            not_full[i]  = (fill[i] != FULL);
            not_empty[i] = (fill[i] != '0);
            push[i]      = in_valid[i] && not_full[i];
        end
    end

    // Round-robin pick: scan starting one past the last granted port, pop
    // only when the output register can take the beat.
    always_comb begin
        out_free    = !m_tvalid || m_tready;
        grant_valid = |not_empty;
        grant_port  = 2'd0;
        case (last_grant)
            2'd0: begin
                if (not_empty[1])      grant_port = 2'd1;
                else if (not_empty[2]) grant_port = 2'd2;
                else                   grant_port = 2'd0;
            end
            2'd1: begin
                if (not_empty[2])      grant_port = 2'd2;
                else if (not_empty[0]) grant_port = 2'd0;
                else                   grant_port = 2'd1;
            end
            default: begin
                if (not_empty[0])      grant_port = 2'd0;
                else if (not_empty[1]) grant_port = 2'd1;
                else                   grant_port = 2'd2;
            end
        endcase
        pop = (out_free && grant_valid) ? (3'b001 << grant_port) : 3'b000;
        case (grant_port)
            2'd1:    head_data = mem[1][rd_ptr[1]];
            2'd2:    head_data = mem[2][rd_ptr[2]];
            default: head_data = mem[0][rd_ptr[0]];
        endcase
    end

    // FIFO storage writes; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= in_data[i];
            end
        end
    end

    // FIFO pointers and occupancy; push+pop together leaves occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                fill[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
                case ({push[i], pop[i]})
                    2'b10:   fill[i] <= fill[i] + CW'(1);
                    2'b01:   fill[i] <= fill[i] - CW'(1);
                    default: fill[i] <= fill[i];
                endcase
            end
        end
    end

    // Output register and grant history; held while stalled, emptied when
    // free with nothing to send.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            last_grant <= 2'd2;
        end else if (out_free) begin
            if (grant_valid) begin
                m_tvalid   <= 1'b1;
                m_tdata    <= {grant_port, head_data};
                last_grant <= grant_port;
            end else begin
                m_tvalid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_merge3.sv
// tb_axi_stream_merge3: directed table, hand-written corner sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_axi_stream_merge3;

  localparam int DATA_W = 22;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              s0_tvalid, s1_tvalid, s2_tvalid;
  logic [DATA_W-1:0] s0_tdata, s1_tdata, s2_tdata;
  logic              s0_tready, s1_tready, s2_tready;
  logic              m_tvalid;
  logic [DATA_W+1:0] m_tdata;
  logic              m_tready;
  logic [2:0]        fill0, fill1, fill2;

  axi_stream_merge3 #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s0_tvalid(s0_tvalid), .s0_tdata(s0_tdata), .s0_tready(s0_tready),
    .s1_tvalid(s1_tvalid), .s1_tdata(s1_tdata), .s1_tready(s1_tready),
    .s2_tvalid(s2_tvalid), .s2_tdata(s2_tdata), .s2_tready(s2_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tready(m_tready),
    .fill0(fill0), .fill1(fill1), .fill2(fill2)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: per-port queues, output register, last grant
  logic [DATA_W-1:0] q0[$], q1[$], q2[$];
  logic              mv;
  logic [DATA_W+1:0] md;
  int                mlg;

  // pre-edge observations of the last step
  logic              out_fire;
  logic [DATA_W+1:0] out_beat;
  logic [2:0]        acc_obs;

  // scoreboard expected queue
  logic [DATA_W+1:0] exp_q[$];

  typedef struct {
    logic              r;
    logic [2:0]        v;
    logic [DATA_W-1:0] d0, d1, d2;
    logic              rdy;
    logic              ev;
    logic [DATA_W+1:0] ed;
    logic [2:0]        f0, f1, f2;
  } vec_t;
  vec_t tbl[$];

  function automatic int qsize(input int p);
    case (p)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] qpop(input int p);
    case (p)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic qpush(input int p, input logic [DATA_W-1:0] d);
    case (p)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // driver: apply one cycle of inputs, advance the model, compare after the edge
  task automatic step(input logic r, input logic [2:0] v, input logic [DATA_W-1:0] a,
                      input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] c, input logic rdy);
    logic [DATA_W-1:0] d [3];
    logic [2:0] acc_m;
    logic found;
    int gp;
    int p;
    rst = r;
    s0_tvalid = v[0]; s1_tvalid = v[1]; s2_tvalid = v[2];
    s0_tdata = a; s1_tdata = b; s2_tdata = c;
    m_tready = rdy;
    #1;
    out_fire = m_tvalid && m_tready;
    out_beat = m_tdata;
    acc_obs  = {s2_tvalid && s2_tready, s1_tvalid && s1_tready, s0_tvalid && s0_tready};
    d[0] = a; d[1] = b; d[2] = c;
    acc_m = '0;
    if (r) begin
      q0.delete(); q1.delete(); q2.delete();
      mv = 1'b0; md = '0; mlg = 2;
    end else begin
      for (int i = 0; i < 3; i++) acc_m[i] = v[i] && (qsize(i) < DEPTH);
      if (!mv || rdy) begin
        found = 1'b0;
        gp = 0;
        for (int k = 1; k <= 3; k++) begin
          p = (mlg + k) % 3;
          if (!found && qsize(p) > 0) begin
            found = 1'b1;
            gp = p;
          end
        end
        if (found) begin
          md  = {2'(gp), qpop(gp)};
          mv  = 1'b1;
          mlg = gp;
        end else begin
          mv = 1'b0;
        end
      end
      for (int i = 0; i < 3; i++) if (acc_m[i]) qpush(i, d[i]);
      chk("accept", 32'(acc_obs), 32'(acc_m));
    end
    @(posedge clk);
    #1;
    chk("m_tvalid", 32'(m_tvalid), 32'(mv));
    chk("m_tdata", 32'(m_tdata), 32'(md));
    chk("fill0", 32'(fill0), 32'(qsize(0)));
    chk("fill1", 32'(fill1), 32'(qsize(1)));
    chk("fill2", 32'(fill2), 32'(qsize(2)));
    chk("s0_tready", 32'(s0_tready), 32'(qsize(0) != DEPTH));
    chk("s1_tready", 32'(s1_tready), 32'(qsize(1) != DEPTH));
    chk("s2_tready", 32'(s2_tready), 32'(qsize(2) != DEPTH));
  endtask

  task automatic add(input logic r, input logic [2:0] v, input logic [DATA_W-1:0] a,
                     input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] c, input logic rdy,
                     input logic ev, input logic [DATA_W+1:0] ed,
                     input logic [2:0] f0, input logic [2:0] f1, input logic [2:0] f2);
    vec_t t;
    t.r = r; t.v = v; t.d0 = a; t.d1 = b; t.d2 = c; t.rdy = rdy;
    t.ev = ev; t.ed = ed; t.f0 = f0; t.f1 = f1; t.f2 = f2;
    tbl.push_back(t);
  endtask

  initial begin
    int k;
    int n_acc;
    int got;
    int cyc;
    int idx;
    int s0_after;
    logic s1_acc, s1_out;
    logic [DATA_W+1:0] held;
    logic held_v;

    rst = 1'b1; m_tready = 1'b0;
    s0_tvalid = 1'b0; s1_tvalid = 1'b0; s2_tvalid = 1'b0;
    s0_tdata = '0; s1_tdata = '0; s2_tdata = '0;
    mv = 1'b0; md = '0; mlg = 2;

    // single beat, then round-robin preload and drain
    add(1, 3'b000, 0, 0, 0, 0, 0, 24'h000000, 0, 0, 0);
    add(0, 3'b010, 0, 22'h00ABC, 0, 1, 0, 24'h000000, 0, 1, 0);
    add(0, 3'b000, 0, 0, 0, 1, 1, 24'h400ABC, 0, 0, 0);
    add(0, 3'b000, 0, 0, 0, 1, 0, 24'h400ABC, 0, 0, 0);
    add(1, 3'b000, 0, 0, 0, 0, 0, 24'h000000, 0, 0, 0);
    add(0, 3'b111, 22'h0A0, 22'h0B0, 22'h0C0, 0, 0, 24'h000000, 1, 1, 1);
    add(0, 3'b111, 22'h0A1, 22'h0B1, 22'h0C1, 0, 1, 24'h0000A0, 1, 2, 2);
    add(0, 3'b111, 22'h0A2, 22'h0B2, 22'h0C2, 0, 1, 24'h0000A0, 2, 3, 3);
    add(0, 3'b000, 0, 0, 0, 1, 1, 24'h4000B0, 2, 2, 3);
    add(0, 3'b000, 0, 0, 0, 1, 1, 24'h8000C0, 2, 2, 2);
    add(0, 3'b000, 0, 0, 0, 1, 1, 24'h0000A1, 1, 2, 2);
    add(0, 3'b000, 0, 0, 0, 1, 1, 24'h4000B1, 1, 1, 2);
    add(0, 3'b000, 0, 0, 0, 1, 1, 24'h8000C1, 1, 1, 1);
    add(0, 3'b000, 0, 0, 0, 1, 1, 24'h0000A2, 0, 1, 1);
    add(0, 3'b000, 0, 0, 0, 1, 1, 24'h4000B2, 0, 0, 1);
    add(0, 3'b000, 0, 0, 0, 1, 1, 24'h8000C2, 0, 0, 0);
    add(0, 3'b000, 0, 0, 0, 1, 0, 24'h8000C2, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].rdy);
      chk($sformatf("tbl%0d_tvalid", i), 32'(m_tvalid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_tdata", i), 32'(m_tdata), 32'(tbl[i].ed));
      chk($sformatf("tbl%0d_fill0", i), 32'(fill0), 32'(tbl[i].f0));
      chk($sformatf("tbl%0d_fill1", i), 32'(fill1), 32'(tbl[i].f1));
      chk($sformatf("tbl%0d_fill2", i), 32'(fill2), 32'(tbl[i].f2));
    end

    // backpressure: s2 streams into a stalled output
    step(1, 3'b000, 0, 0, 0, 0);
    k = 0; n_acc = 0; held_v = 1'b0; held = '0;
    for (int i = 0; i < 8; i++) begin
      step(0, 3'b100, 0, 0, 22'(32'h300 + k), 0);
      if (acc_obs[2]) begin
        k++;
        n_acc++;
      end
      if (held_v) chk("bp_stable", 32'(m_tdata), 32'(held));
      if (m_tvalid && !held_v) begin
        held_v = 1'b1;
        held = m_tdata;
      end
    end
    chk("bp_accepts", 32'(n_acc), 32'd5);
    chk("bp_fill2", 32'(fill2), 32'd4);
    chk("bp_s2_tready", 32'(s2_tready), 32'd0);
    chk("bp_hold_data", 32'(m_tdata), 32'h800300);

    // fairness: s0 busy every cycle, s1 sends a single beat
    step(1, 3'b000, 0, 0, 0, 0);
    exp_q.delete();
    k = 0; s0_after = 0; s1_acc = 1'b0; s1_out = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step(0, {1'b0, c == 3, c < 30}, 22'(32'h100 + k), 22'h222, 0, 1);
      if (out_fire) begin
        if (out_beat == 24'h400222) begin
          s1_out = 1'b1;
          chk("fair_wait", 32'(s0_after <= 2), 32'd1);
        end else if (exp_q.size() > 0) begin
          chk("fair_s0_order", 32'(out_beat), 32'(exp_q.pop_front()));
          if (s1_acc && !s1_out) s0_after++;
        end else begin
          chk("fair_extra_beat", 32'(out_beat), 32'hFFFFFFFF);
        end
      end
      if (acc_obs[0]) begin
        exp_q.push_back({2'd0, 22'(32'h100 + k)});
        k++;
      end
      if (acc_obs[1]) s1_acc = 1'b1;
    end
    chk("fair_s1_seen", 32'(s1_out), 32'd1);
    chk("fair_s0_drained", 32'(exp_q.size()), 32'd0);

    // wrap-around: 20 beats through port 0 with random m_tready
    step(1, 3'b000, 0, 0, 0, 0);
    exp_q.delete();
    idx = 0; got = 0; cyc = 0;
    while (got < 20 && cyc < 600) begin
      step(0, {2'b00, idx < 20}, 22'(idx), 0, 0, 1'($urandom_range(0, 1)));
      if (out_fire) begin
        got++;
        if (exp_q.size() > 0) chk("wrap_data", 32'(out_beat), 32'(exp_q.pop_front()));
        else chk("wrap_extra_beat", 32'(out_beat), 32'hFFFFFFFF);
      end
      if (acc_obs[0]) begin
        exp_q.push_back({2'd0, 22'(idx)});
        idx++;
      end
      chk("wrap_fill0_max", 32'(fill0 <= 3'd4), 32'd1);
      cyc++;
    end
    chk("wrap_count", 32'(got), 32'd20);

    // reset mid-operation with partly filled FIFOs and a valid output
    step(0, 3'b011, 22'(32'h55), 22'(32'h66), 0, 0);
    step(0, 3'b011, 22'(32'h57), 22'(32'h68), 0, 0);
    chk("pre_reset_valid", 32'(m_tvalid), 32'd1);
    step(1, 3'b111, 22'(32'h77), 22'(32'h78), 22'(32'h79), 0);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_fills", 32'({fill2, fill1, fill0}), 32'd0);
    chk("rst_treadys", 32'({s2_tready, s1_tready, s0_tready}), 32'd7);
    step(0, 3'b111, 22'h11, 22'h22, 22'h33, 1);
    step(0, 3'b000, 0, 0, 0, 1);
    chk("post_rst_grant", 32'(m_tdata), 32'h000011);
    chk("post_rst_valid", 32'(m_tvalid), 32'd1);

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 99) == 0), 3'($urandom_range(0, 7)),
           22'($urandom), 22'($urandom), 22'($urandom),
           (i < 300) ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
